// File: rtl/mascara_pkg.sv
// Shared definitions for the mask writer and the mask-index reader: FSM states,
// default widths and the N -> (total, valid) rule both sides must agree on.
package mascara_pkg;

  localparam int BITS_INDICE_MASCARA_DEF = 10;
  localparam int BITS_MASCARA_DEF        = 5;
  localparam int BITS_COEFICIENTE_DEF    = 16;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CALCULO = 2'd1,
    CARGA   = 2'd2,
    FIN     = 2'd3
  } estado_t;

  typedef struct packed {
    logic [31:0] total;
    logic        valido;
  } tamano_info_t;

  // A mask side is usable only if it is odd, non-zero and N*N fits the memory.
  function automatic tamano_info_t calcular_total(input logic [15:0] n,
                                                  input int unsigned bits_indice);
    tamano_info_t r;
    r.total  = 32'(n) * 32'(n);
    r.valido = (n != 16'd0) && n[0] &&
               ({1'b0, r.total} <= (33'd1 << bits_indice));
    return r;
  endfunction

endpackage

// File: rtl/cargador_mascara_if.sv
// Coefficient stream, mask-memory write port and status of the mask writer.
// Optional suma_coeficientes exists only with CARGADOR_MASCARA_SUMA_EN defined.
interface cargador_mascara_if
  import mascara_pkg::*;
#(
  parameter int BITS_INDICE_MASCARA = BITS_INDICE_MASCARA_DEF,
  parameter int BITS_MASCARA        = BITS_MASCARA_DEF,
  parameter int BITS_COEFICIENTE    = BITS_COEFICIENTE_DEF
);

  logic                                     inicio;
  logic        [BITS_MASCARA-1:0]           tamano_mascara;
  logic signed [BITS_COEFICIENTE-1:0]       coef_entrada;
  logic                                     coef_valido;
  logic                                     coef_listo;
  logic        [BITS_INDICE_MASCARA-1:0]    mem_direccion;
  logic signed [BITS_COEFICIENTE-1:0]       mem_dato;
  logic                                     mem_escritura;
  logic                                     ocupado;
  logic                                     carga_completa;
  logic                                     error_tamano;
`ifdef CARGADOR_MASCARA_SUMA_EN
  logic signed [BITS_COEFICIENTE+BITS_INDICE_MASCARA-1:0] suma_coeficientes;

  modport master (
    output inicio, tamano_mascara, coef_entrada, coef_valido,
    input  coef_listo, mem_direccion, mem_dato, mem_escritura,
    input  ocupado, carga_completa, error_tamano, suma_coeficientes
  );

  modport slave (
    input  inicio, tamano_mascara, coef_entrada, coef_valido,
    output coef_listo, mem_direccion, mem_dato, mem_escritura,
    output ocupado, carga_completa, error_tamano, suma_coeficientes
  );
`else
  modport master (
    output inicio, tamano_mascara, coef_entrada, coef_valido,
    input  coef_listo, mem_direccion, mem_dato, mem_escritura,
    input  ocupado, carga_completa, error_tamano
  );

  modport slave (
    input  inicio, tamano_mascara, coef_entrada, coef_valido,
    output coef_listo, mem_direccion, mem_dato, mem_escritura,
    output ocupado, carga_completa, error_tamano
  );
`endif

endinterface

// File: rtl/cargador_mascara_ffd.sv
// Enabled D register with synchronous active-low reset (FlipFlopD_Habilitado),
// used to hold the latched mask side.
module FlipFlopD_Habilitado #(
  parameter int BITS_EN_REGISTRO = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        habilitar,
  input  logic [BITS_EN_REGISTRO-1:0] d,
  output logic [BITS_EN_REGISTRO-1:0] q
);

  logic [BITS_EN_REGISTRO-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= '0;
    end else if (habilitar) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cargador_mascara.sv
// Mask coefficient writer: accepts N*N coefficients and writes them in raster order.
// Define CARGADOR_MASCARA_SUMA_EN to add the running coefficient sum output.
module cargador_mascara
  import mascara_pkg::*;
#(
  parameter int BITS_INDICE_MASCARA = BITS_INDICE_MASCARA_DEF,
  parameter int BITS_MASCARA        = BITS_MASCARA_DEF,
  parameter int BITS_COEFICIENTE    = BITS_COEFICIENTE_DEF
) (
  input  logic            clk,
  input  logic            reset,
  cargador_mascara_if.slave bus
);

  localparam int BI = BITS_INDICE_MASCARA;
  localparam int BC = BITS_COEFICIENTE;

  estado_t                estado_q;
  logic [BITS_MASCARA-1:0] n_q;
  logic [BI-1:0]          indice_q;
  logic [BI-1:0]          ultimo_q;
  logic                   coef_listo_q;
  logic                   ocupado_q;
  logic                   carga_completa_q;
  logic                   error_q;
  logic                   mem_escritura_q;
  logic [BI-1:0]          mem_direccion_q;
  logic signed [BC-1:0]   mem_dato_q;

  logic                   cargar_n_d;
  logic                   transferencia_d;
  tamano_info_t           info_d;

  assign cargar_n_d      = (estado_q == REPOSO) && bus.inicio;
  assign transferencia_d = bus.coef_valido && coef_listo_q;
  assign info_d          = calcular_total(16'(n_q), BI);

  FlipFlopD_Habilitado #(
    .BITS_EN_REGISTRO (BITS_MASCARA)
  ) u_latch_n (
    .clk       (clk),
    .reset     (reset),
    .habilitar (cargar_n_d),
    .d         (bus.tamano_mascara),
    .q         (n_q)
  );

  // coef_listo is only ever high in CARGA, so transferencia_d implies CARGA
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q         <= REPOSO;
      indice_q         <= '0;
      ultimo_q         <= '0;
      coef_listo_q     <= 1'b0;
      ocupado_q        <= 1'b0;
      carga_completa_q <= 1'b0;
      error_q          <= 1'b0;
      mem_escritura_q  <= 1'b0;
      mem_direccion_q  <= '0;
      mem_dato_q       <= '0;
    end else begin
      mem_escritura_q  <= 1'b0;
      carga_completa_q <= 1'b0;
      case (estado_q)
        REPOSO: begin
          if (bus.inicio) begin
            estado_q  <= CALCULO;
            ocupado_q <= 1'b1;
            error_q   <= 1'b0;
            indice_q  <= '0;
          end
        end
        CALCULO: begin
          if (info_d.valido) begin
            estado_q     <= CARGA;
            coef_listo_q <= 1'b1;
            ultimo_q     <= BI'(info_d.total - 32'd1);
          end else begin
            estado_q  <= REPOSO;
            ocupado_q <= 1'b0;
            error_q   <= 1'b1;
          end
        end
        CARGA: begin
          if (transferencia_d) begin
            mem_escritura_q <= 1'b1;
            mem_direccion_q <= indice_q;
            mem_dato_q      <= bus.coef_entrada;
            // the index stops at total-1 instead of wrapping
            if (indice_q == ultimo_q) begin
              estado_q         <= FIN;
              coef_listo_q     <= 1'b0;
              carga_completa_q <= 1'b1;
            end else begin
              indice_q <= indice_q + BI'(1);
            end
          end
        end
        FIN: begin
          estado_q  <= REPOSO;
          ocupado_q <= 1'b0;
        end
        default: begin
          estado_q     <= REPOSO;
          ocupado_q    <= 1'b0;
          coef_listo_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef CARGADOR_MASCARA_SUMA_EN
  logic signed [BC+BI-1:0] suma_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      suma_q <= '0;
    end else if (cargar_n_d) begin
      suma_q <= '0;
    end else if (transferencia_d) begin
      suma_q <= suma_q + $signed({{BI{bus.coef_entrada[BC-1]}}, bus.coef_entrada});
    end
  end

  assign bus.suma_coeficientes = suma_q;
`endif

  assign bus.coef_listo     = coef_listo_q;
  assign bus.ocupado        = ocupado_q;
  assign bus.carga_completa = carga_completa_q;
  assign bus.error_tamano   = error_q;
  assign bus.mem_escritura  = mem_escritura_q;
  assign bus.mem_direccion  = mem_direccion_q;
  assign bus.mem_dato       = mem_dato_q;

endmodule

// File: tb/tb_cargador_mascara.sv
// Directed/randomized bench for cargador_mascara; expected writes come from the
// load rules (one write per accepted coefficient, raster addresses, N*N total).
module tb_cargador_mascara;

  localparam int BI = 10;
  localparam int BM = 6;
  localparam int BC = 16;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  cargador_mascara_if #(
    .BITS_INDICE_MASCARA (BI),
    .BITS_MASCARA        (BM),
    .BITS_COEFICIENTE    (BC)
  ) bus ();

  cargador_mascara #(
    .BITS_INDICE_MASCARA (BI),
    .BITS_MASCARA        (BM),
    .BITS_COEFICIENTE    (BC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_todo_cero(input string tag);
    chk({tag, "_ocupado"}, 64'(bus.ocupado), 64'd0);
    chk({tag, "_listo"}, 64'(bus.coef_listo), 64'd0);
    chk({tag, "_we"}, 64'(bus.mem_escritura), 64'd0);
    chk({tag, "_dir"}, 64'(bus.mem_direccion), 64'd0);
    chk({tag, "_dato"}, 64'(unsigned'(bus.mem_dato)), 64'd0);
    chk({tag, "_completa"}, 64'(bus.carga_completa), 64'd0);
    chk({tag, "_error"}, 64'(bus.error_tamano), 64'd0);
`ifdef CARGADOR_MASCARA_SUMA_EN
    chk({tag, "_suma"}, {38'd0, bus.suma_coeficientes}, 64'd0);
`endif
  endtask

  // modo: 0 valid held, random data; 1 valid pattern 1,0,0; 2 random valid plus
  // stray inicio pulses; 3 valid held, data 1..total. abortar>0: reset after that many writes.
  task automatic cargar(input int n, input int modo, input int abortar);
    int          total;
    int          cnt;
    int          ciclos;
    int          limite;
    int          suma;
    bit          n_ok;
    bit          v;
    logic [BC-1:0] dato;
    logic [25:0] suma_esp;

    total  = n * n;
    n_ok   = (n != 0) && (n % 2 == 1) && (total <= (1 << BI));
    limite = 4 * total + 20;

    bus.inicio         = 1'b1;
    bus.tamano_mascara = BM'(n);
    bus.coef_valido    = 1'b1;
    bus.coef_entrada   = BC'($urandom);
    tick();
    bus.inicio         = 1'b0;
    bus.tamano_mascara = BM'($urandom);
    chk("calc_ocupado", 64'(bus.ocupado), 64'd1);
    chk("calc_listo", 64'(bus.coef_listo), 64'd0);
    chk("calc_error", 64'(bus.error_tamano), 64'd0);
    chk("calc_we", 64'(bus.mem_escritura), 64'd0);
    tick();

    if (!n_ok) begin
      chk("inval_error", 64'(bus.error_tamano), 64'd1);
      chk("inval_ocupado", 64'(bus.ocupado), 64'd0);
      chk("inval_listo", 64'(bus.coef_listo), 64'd0);
      chk("inval_we", 64'(bus.mem_escritura), 64'd0);
      repeat (3) begin
        tick();
        chk("inval_we_despues", 64'(bus.mem_escritura), 64'd0);
        chk("inval_error_pegajoso", 64'(bus.error_tamano), 64'd1);
      end
      bus.coef_valido = 1'b0;
      return;
    end

    chk("carga_listo", 64'(bus.coef_listo), 64'd1);
    chk("carga_ocupado", 64'(bus.ocupado), 64'd1);
    chk("carga_error", 64'(bus.error_tamano), 64'd0);

    cnt    = 0;
    suma   = 0;
    ciclos = 0;
    while (cnt < total) begin
      case (modo)
        1:       v = (ciclos % 3 == 0);
        2:       v = 1'($urandom_range(0, 1));
        default: v = 1'b1;
      endcase
      dato = (modo == 3) ? BC'(cnt + 1) : BC'($urandom);
      bus.coef_valido  = v;
      bus.coef_entrada = dato;
      if (modo == 2) begin
        bus.inicio         = ($urandom_range(0, 3) == 0);
        bus.tamano_mascara = BM'($urandom);
      end
      tick();
      ciclos++;
      bus.inicio = 1'b0;
      if (v) begin
        chk("we", 64'(bus.mem_escritura), 64'd1);
        chk("dir", 64'(bus.mem_direccion), 64'(cnt));
        chk("dato", 64'(unsigned'(bus.mem_dato)), 64'(dato));
        suma += int'($signed(dato));
        cnt++;
      end else begin
        chk("we_hueco", 64'(bus.mem_escritura), 64'd0);
      end
      chk("completa", 64'(bus.carga_completa), 64'(v && (cnt == total)));
      chk("listo", 64'(bus.coef_listo), 64'(cnt < total));
      if (abortar > 0 && cnt == abortar) begin
        reset           = 1'b0;
        bus.coef_valido = 1'b1;
        tick();
        chk_todo_cero("abort");
        reset = 1'b1;
        repeat (3) begin
          tick();
          chk("abort_we", 64'(bus.mem_escritura), 64'd0);
          chk("abort_ocupado", 64'(bus.ocupado), 64'd0);
        end
        bus.coef_valido = 1'b0;
        return;
      end
      if (ciclos > limite) begin
        chk("timeout_carga", 64'(cnt), 64'(total));
        break;
      end
    end

    suma_esp = 26'(suma);
`ifdef CARGADOR_MASCARA_SUMA_EN
    chk("suma_fin", {38'd0, bus.suma_coeficientes}, {38'd0, suma_esp});
`endif
    bus.coef_valido = 1'b1;
    tick();
    chk("post_ocupado", 64'(bus.ocupado), 64'd0);
    chk("post_we", 64'(bus.mem_escritura), 64'd0);
    chk("post_completa", 64'(bus.carga_completa), 64'd0);
    chk("post_listo", 64'(bus.coef_listo), 64'd0);
`ifdef CARGADOR_MASCARA_SUMA_EN
    chk("suma_estable", {38'd0, bus.suma_coeficientes}, {38'd0, suma_esp});
`endif
    bus.coef_valido = 1'b0;
  endtask

  initial begin
    n_checks           = 0;
    n_errors           = 0;
    reset              = 1'b0;
    bus.inicio         = 1'b0;
    bus.tamano_mascara = '0;
    bus.coef_entrada   = '0;
    bus.coef_valido    = 1'b0;
    repeat (3) tick();
    chk_todo_cero("reset");
    reset = 1'b1;
    tick();

    cargar(3, 3, 0);
    cargar(3, 1, 0);
    cargar(4, 0, 0);
    cargar(0, 0, 0);
    cargar(3, 2, 0);
    cargar(31, 0, 0);
    cargar(33, 0, 0);
    cargar(1, 0, 0);
    cargar(32, 0, 0);
    cargar(63, 0, 0);
    cargar(5, 2, 10);
    cargar(5, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cargar(2 * int'($urandom_range(0, 4)) + 1, 2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cargador_mascara.md
# cargador_mascara

Writer side of the filter-mask coefficient store. It accepts a stream of mask coefficients over a valid/ready handshake and writes them in raster order into the mask memory, at addresses 0 .. N·N−1. It then pulses completion. It is the load counterpart of the mask-index reader, which later walks the same addresses during filtering. It sits between the configuration/host register path and the mask memory write port.

## Interface
Parameters:
- BITS_INDICE_MASCARA, 10, width of mask memory address (capacity 2^BITS_INDICE_MASCARA coefficients)
- BITS_MASCARA, 5, width of mask side size N
- BITS_COEFICIENTE, 16, width of one signed two's-complement coefficient

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- inicio  in  1  start pulse, sampled only in REPOSO
- tamano_mascara  in  BITS_MASCARA  mask side N (3 = 3x3), sampled with inicio
- coef_entrada  in  BITS_COEFICIENTE  coefficient data
- coef_valido  in  1  coef_entrada valid
- coef_listo  out  1  block accepts a coefficient this cycle
- mem_direccion  out  BITS_INDICE_MASCARA  write address
- mem_dato  out  BITS_COEFICIENTE  write data
- mem_escritura  out  1  write strobe
- ocupado  out  1  high in every state except REPOSO
- carga_completa  out  1  one-cycle pulse at end of a successful load
- error_tamano  out  1  sticky; set on invalid N, cleared by the next accepted inicio

## Operation
- FSM states: REPOSO, CALCULO, CARGA, FIN.
- REPOSO:
  - inicio=1 latches N, clears error_tamano and the index counter, and goes to CALCULO.
  - Otherwise the block stays in REPOSO.
- CALCULO:
  - total = N·N, computed at width 2·BITS_MASCARA.
  - N invalid if N==0, N even, or total > 2^BITS_INDICE_MASCARA.
  - Invalid N: set error_tamano, go to REPOSO, perform no writes.
  - Valid N: go to CARGA.
- CARGA:
  - coef_listo=1.
  - Transfer occurs when coef_valido && coef_listo.
  - Each transfer registers the address (index), data and strobe, then increments the index.
  - The transfer at index total−1 moves the FSM to FIN.
- FIN: carga_completa=1 for one cycle, coef_listo=0, then REPOSO.
- inicio outside REPOSO is ignored.
- coef_valido outside CARGA is ignored; nothing is accepted.
- The index counter never wraps. Its maximum value is total−1, which is ≤ 2^BITS_INDICE_MASCARA−1.

## Timing
- Reset values: all outputs 0, FSM in REPOSO, index 0, error_tamano 0.
- Reset asserted mid-load: the load is aborted at the next edge and no further writes occur. Coefficients already written remain in memory.
- inicio at cycle t gives CALCULO at t+1, then CARGA (coef_listo=1) or REPOSO (error_tamano=1) at t+2.
- Transfer at cycle k gives mem_escritura=1 with mem_direccion/mem_dato at k+1. Latency is one cycle and back-to-back transfers give back-to-back writes.
- mem_escritura is 0 in every cycle with no preceding transfer. mem_direccion and mem_dato hold their last values.
- Last transfer at cycle k:
  - The final write and carga_completa both occur at k+1.
  - coef_listo=0 at k+1.
  - ocupado=0 at k+2.
- Minimum period from inicio to carga_completa: total+2 cycles.

## Configuration
- Macro CARGADOR_MASCARA_SUMA_EN.
- Defined: adds output suma_coeficientes (signed, BITS_COEFICIENTE+BITS_INDICE_MASCARA bits).
  - Cleared by the accepted inicio.
  - Accumulates each transferred coefficient, sign-extended.
  - Valid and stable from the carga_completa cycle until the next inicio.
  - Used by the normalizer.
- Undefined: the port and the accumulator are absent; all other behaviour is identical.

## Structure
- Shared package mascara_pkg holds:
  - FSM state enum (REPOSO, CALCULO, CARGA, FIN).
  - Default widths as localparams.
  - A function computing total and validity from N, reused by the reader side.
- The N latch is one instance of the existing FlipFlopD_Habilitado, with BITS_EN_REGISTRO = BITS_MASCARA and enabled by inicio in REPOSO.
- No other sub-module.

## Test plan
- N=3, coefficients 1..9 sent with coef_valido held high:
  - Writes at addresses 0..8 with data 1..9 on consecutive cycles.
  - carga_completa in the same cycle as the address-8 write.
  - suma_coeficientes=45 when the macro is defined.
- N=3 with coef_valido toggled 1,0,0,1,...:
  - Exactly 9 writes, addresses contiguous.
  - mem_escritura=0 in each cycle following a gap.
- N=4, then N=0:
  - error_tamano=1 at t+2.
  - No mem_escritura.
  - ocupado=0 at t+2.
  - The next valid inicio clears error_tamano.
- N=31, BITS_INDICE_MASCARA=10: 961 writes, last address 960.
- N=33 with BITS_MASCARA=6: 1089 > 1024, so error_tamano=1.
- N=5, reset asserted after 10 transfers:
  - All outputs 0 on the next cycle, no further writes.
  - A new inicio restarts from address 0.
  - inicio pulsed during CARGA has no effect on the index.
